// File: rtl/fetch_pc_stage.sv
// Fetch PC register, single-outstanding instruction-memory requester and IF/ID stage with skid buffer.
// Optional fetch/flush counters are enabled by defining FETCH_STATS_EN.
module fetch_pc_stage #(
    parameter int unsigned          DataWidth = 32,
    parameter logic [DataWidth-1:0] ResetPC   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DataWidth-1:0] NextPC,
    input  logic                 PCSrc,
    output logic [DataWidth-1:0] PCPlus4,
    output logic [DataWidth-1:0] PCF,
    output logic                 IMemReq,
    output logic [DataWidth-1:0] IMemAddr,
    input  logic                 IMemRdy,
    input  logic                 IMemRValid,
    input  logic [DataWidth-1:0] IMemRData,
    input  logic                 StallD,
    output logic                 ValidD,
    output logic [DataWidth-1:0] InstrD,
    output logic [DataWidth-1:0] PCD
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]          FetchCount,
    output logic [31:0]          FlushCount
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic                 drop, drop_nxt;
    logic                 validd_nxt;
    logic                 load;
    logic                 ifid_free;
    logic [DataWidth-1:0] pcf_nxt;
    logic [DataWidth-1:0] instrd_nxt, pcd_nxt;
    logic [DataWidth-1:0] skid_instr, skid_pc;
    logic [DataWidth-1:0] skid_instr_nxt, skid_pc_nxt;

    assign PCPlus4   = PCF + {{(DataWidth-3){1'b0}}, 3'd4};
    assign IMemReq   = (state == S_REQ) && !reset;
    assign IMemAddr  = PCF;
    assign ifid_free = !ValidD || !StallD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            drop       <= 1'b0;
            PCF        <= ResetPC;
            ValidD     <= 1'b0;
            InstrD     <= '0;
            PCD        <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state      <= state_nxt;
            drop       <= drop_nxt;
            PCF        <= pcf_nxt;
            ValidD     <= validd_nxt;
            InstrD     <= instrd_nxt;
            PCD        <= pcd_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        drop_nxt       = drop;
        pcf_nxt        = PCF;
        validd_nxt     = ValidD;
        instrd_nxt     = InstrD;
        pcd_nxt        = PCD;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;
        load           = 1'b0;

        if (PCSrc) begin
            // Redirect wins: squash IF/ID and skid; remember a stale response still owed by memory.
            pcf_nxt        = NextPC;
            validd_nxt     = 1'b0;
            skid_instr_nxt = '0;
            skid_pc_nxt    = '0;
            drop_nxt       = 1'b0;
            state_nxt      = S_REQ;
            case (state)
                S_REQ: begin
                    if (IMemRdy) begin
                        state_nxt = S_WAIT;
                        drop_nxt  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!IMemRValid) begin
                        state_nxt = S_WAIT;
                        drop_nxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            if (ValidD && !StallD) begin
                validd_nxt = 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (IMemRdy) begin
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (IMemRValid) begin
                        if (drop) begin
                            drop_nxt  = 1'b0;
                            state_nxt = S_REQ;
                        end else if (ifid_free) begin
                            load       = 1'b1;
                            instrd_nxt = IMemRData;
                            pcd_nxt    = PCF;
                            pcf_nxt    = NextPC;
                            state_nxt  = S_REQ;
                        end else begin
                            skid_instr_nxt = IMemRData;
                            skid_pc_nxt    = PCF;
                            state_nxt      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!StallD) begin
                        load       = 1'b1;
                        instrd_nxt = skid_instr;
                        pcd_nxt    = skid_pc;
                        pcf_nxt    = NextPC;
                        state_nxt  = S_REQ;
                    end
                end
                default: state_nxt = S_REQ;
            endcase
            if (load) begin
                validd_nxt = 1'b1;
            end
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            FetchCount <= '0;
            FlushCount <= '0;
        end else begin
            if (load) begin
                FetchCount <= FetchCount + 32'd1;
            end
            if (PCSrc) begin
                FlushCount <= FlushCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Bench for fetch_pc_stage: directed vector table for the multi-cycle corner cases,
// then randomized traffic checked against a queue-based transaction model.
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] NextPC;
    logic        PCSrc;
    logic [31:0] PCPlus4;
    logic [31:0] PCF;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemRdy;
    logic        IMemRValid;
    logic [31:0] IMemRData;
    logic        StallD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
`ifdef FETCH_STATS_EN
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;
`endif

    always #5 clk = ~clk;

    fetch_pc_stage #(
        .DataWidth(32),
        .ResetPC  (32'h0000_0100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .NextPC    (NextPC),
        .PCSrc     (PCSrc),
        .PCPlus4   (PCPlus4),
        .PCF       (PCF),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemRdy   (IMemRdy),
        .IMemRValid(IMemRValid),
        .IMemRData (IMemRData),
        .StallD    (StallD),
        .ValidD    (ValidD),
        .InstrD    (InstrD),
        .PCD       (PCD)
`ifdef FETCH_STATS_EN
        ,
        .FetchCount(FetchCount),
        .FlushCount(FlushCount)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        pcsrc;
        logic [31:0] npc;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        st;
        logic        chk;
        logic        ereq;
        logic [31:0] eaddr;
        logic [31:0] ep4;
        logic        ev;
        logic        chkd;
        logic [31:0] ei;
        logic [31:0] epcd;
    } vec_t;

    function automatic vec_t v(logic rst, logic pcsrc, logic [31:0] npc, logic rdy, logic rv,
                               logic [31:0] rd, logic st, logic ck, logic ereq,
                               logic [31:0] eaddr, logic [31:0] ep4, logic ev, logic chkd,
                               logic [31:0] ei, logic [31:0] epcd);
        vec_t r;
        r.rst = rst; r.pcsrc = pcsrc; r.npc = npc; r.rdy = rdy; r.rv = rv; r.rd = rd;
        r.st = st; r.chk = ck; r.ereq = ereq; r.eaddr = eaddr; r.ep4 = ep4; r.ev = ev;
        r.chkd = chkd; r.ei = ei; r.epcd = epcd;
        return r;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    // Transaction-level model: an outstanding-request flag plus a FIFO of delivered
    // instructions (head = IF/ID, second entry = word parked because decode stalled).
    logic [31:0] m_pc = 32'h100;
    bit          m_req_out = 1'b0;
    bit          m_drop = 1'b0;
    ent_t        m_q[$];
    logic [31:0] m_fetch = '0;
    logic [31:0] m_flush = '0;

    localparam logic [31:0] I0 = 32'h1111_0000, I1 = 32'h2222_0001, I2 = 32'h3333_0002;
    localparam logic [31:0] I3 = 32'h4444_0003, I4 = 32'h5555_0004, I5 = 32'h6666_0005;
    localparam logic [31:0] I6 = 32'h7777_0006, I7 = 32'h8888_0007, I8 = 32'h9999_0008;

    initial begin
        vec_t vecs[$];
        logic [31:0] tgt;
        int pre;
        bit was_req, was_hold;

        reset = 1'b1; PCSrc = 1'b0; NextPC = '0; IMemRdy = 1'b0;
        IMemRValid = 1'b0; IMemRData = '0; StallD = 1'b0;

        //          rst pcs npc            rdy rv rd             st chk req addr           p4            v  chkd instr pcd
        vecs.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0, 32'h0));
        vecs.push_back(v(1, 0, 32'h0,        0, 0, 32'h0,         0, 1, 0, 32'h100,      32'h104,      0, 1, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h104,      1, 0, 32'h0,         0, 1, 1, 32'h100,      32'h104,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h104,      0, 1, I0,            0, 1, 0, 32'h100,      32'h104,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h108,      1, 0, 32'h0,         0, 1, 1, 32'h104,      32'h108,      1, 1, I0, 32'h100));
        vecs.push_back(v(0, 0, 32'h108,      0, 1, I1,            0, 1, 0, 32'h104,      32'h108,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h10C,      1, 0, 32'h0,         0, 1, 1, 32'h108,      32'h10C,      1, 1, I1, 32'h104));
        vecs.push_back(v(0, 0, 32'h10C,      0, 1, I2,            1, 1, 0, 32'h108,      32'h10C,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h110,      1, 0, 32'h0,         1, 1, 1, 32'h10C,      32'h110,      1, 1, I2, 32'h108));
        vecs.push_back(v(0, 0, 32'h110,      0, 1, I3,            1, 1, 0, 32'h10C,      32'h110,      1, 1, I2, 32'h108));
        vecs.push_back(v(0, 0, 32'h110,      1, 0, 32'h0,         1, 1, 0, 32'h10C,      32'h110,      1, 1, I2, 32'h108));
        vecs.push_back(v(0, 0, 32'h110,      0, 0, 32'h0,         0, 1, 0, 32'h10C,      32'h110,      1, 1, I2, 32'h108));
        vecs.push_back(v(0, 0, 32'h114,      0, 0, 32'h0,         0, 1, 1, 32'h110,      32'h114,      1, 1, I3, 32'h10C));
        vecs.push_back(v(0, 0, 32'h114,      1, 0, 32'h0,         0, 1, 1, 32'h110,      32'h114,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 1, 32'h200,      0, 0, 32'h0,         0, 1, 0, 32'h110,      32'h114,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h204,      0, 0, 32'h0,         0, 1, 0, 32'h200,      32'h204,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h204,      0, 1, 32'hDEAD_BEEF, 0, 1, 0, 32'h200,      32'h204,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h204,      0, 0, 32'h0,         0, 1, 1, 32'h200,      32'h204,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h204,      1, 0, 32'h0,         0, 1, 1, 32'h200,      32'h204,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h204,      0, 1, I4,            0, 1, 0, 32'h200,      32'h204,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 1, 32'h300,      1, 0, 32'h0,         0, 1, 1, 32'h204,      32'h208,      1, 1, I4, 32'h200));
        vecs.push_back(v(0, 0, 32'h304,      0, 1, 32'hBAD0_BAD0, 0, 1, 0, 32'h300,      32'h304,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h304,      1, 0, 32'h0,         0, 1, 1, 32'h300,      32'h304,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h304,      0, 1, I5,            0, 1, 0, 32'h300,      32'h304,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,        0, 1, 1, 32'h304,      32'h308,      1, 1, I5, 32'h300));
        vecs.push_back(v(0, 0, 32'h0,        1, 0, 32'h0,         0, 1, 1, 32'hFFFF_FFFC, 32'h0,       0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h0,        0, 1, I6,            0, 1, 0, 32'hFFFF_FFFC, 32'h0,       0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h4,        0, 0, 32'h0,         1, 1, 1, 32'h0,        32'h4,        1, 1, I6, 32'hFFFF_FFFC));
        vecs.push_back(v(0, 0, 32'h4,        1, 0, 32'h0,         1, 1, 1, 32'h0,        32'h4,        1, 1, I6, 32'hFFFF_FFFC));
        vecs.push_back(v(0, 0, 32'h4,        0, 1, I7,            1, 1, 0, 32'h0,        32'h4,        1, 1, I6, 32'hFFFF_FFFC));
        vecs.push_back(v(1, 0, 32'h4,        0, 0, 32'h0,         1, 1, 0, 32'h0,        32'h4,        1, 1, I6, 32'hFFFF_FFFC));
        vecs.push_back(v(1, 0, 32'h104,      0, 0, 32'h0,         0, 1, 0, 32'h100,      32'h104,      0, 1, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h104,      0, 1, 32'h5757_5757, 0, 1, 1, 32'h100,      32'h104,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h104,      1, 0, 32'h0,         0, 1, 1, 32'h100,      32'h104,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h104,      0, 1, I8,            0, 1, 0, 32'h100,      32'h104,      0, 0, 32'h0, 32'h0));
        vecs.push_back(v(0, 0, 32'h108,      0, 0, 32'h0,         0, 1, 1, 32'h104,      32'h108,      1, 1, I8, 32'h100));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; PCSrc = vecs[i].pcsrc; NextPC = vecs[i].npc;
            IMemRdy = vecs[i].rdy; IMemRValid = vecs[i].rv; IMemRData = vecs[i].rd;
            StallD = vecs[i].st;
            #1;
            if (vecs[i].chk) begin
                chk($sformatf("dir%0d.IMemReq", i),  {31'b0, IMemReq}, {31'b0, vecs[i].ereq});
                chk($sformatf("dir%0d.IMemAddr", i), IMemAddr, vecs[i].eaddr);
                chk($sformatf("dir%0d.PCF", i),      PCF, vecs[i].eaddr);
                chk($sformatf("dir%0d.PCPlus4", i),  PCPlus4, vecs[i].ep4);
                chk($sformatf("dir%0d.ValidD", i),   {31'b0, ValidD}, {31'b0, vecs[i].ev});
                if (vecs[i].chkd) begin
                    chk($sformatf("dir%0d.InstrD", i), InstrD, vecs[i].ei);
                    chk($sformatf("dir%0d.PCD", i),    PCD, vecs[i].epcd);
                end
            end
            @(posedge clk);
        end

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            reset      = (cyc < 2) || ($urandom_range(0, 149) == 0);
            PCSrc      = ($urandom_range(0, 9) == 0);
            tgt        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            NextPC     = PCSrc ? tgt : m_pc + 32'd4;
            IMemRdy    = $urandom_range(0, 1) == 1;
            IMemRValid = $urandom_range(0, 1) == 1;
            IMemRData  = $urandom();
            StallD     = ($urandom_range(0, 2) == 0);
            #1;
            if (cyc >= 1) begin
                chk("rnd.IMemReq", {31'b0, IMemReq},
                    {31'b0, (!reset && !m_req_out && m_q.size() < 2)});
                chk("rnd.PCF",      PCF, m_pc);
                chk("rnd.IMemAddr", IMemAddr, m_pc);
                chk("rnd.PCPlus4",  PCPlus4, m_pc + 32'd4);
                chk("rnd.ValidD",   {31'b0, ValidD}, {31'b0, (m_q.size() > 0)});
                if (m_q.size() > 0) begin
                    chk("rnd.InstrD", InstrD, m_q[0].instr);
                    chk("rnd.PCD",    PCD, m_q[0].pc);
                end
`ifdef FETCH_STATS_EN
                chk("rnd.FetchCount", FetchCount, m_fetch);
                chk("rnd.FlushCount", FlushCount, m_flush);
`endif
            end
            @(posedge clk);
            if (reset) begin
                m_pc = 32'h100; m_req_out = 1'b0; m_drop = 1'b0; m_q.delete();
                m_fetch = '0; m_flush = '0;
            end else if (PCSrc) begin
                m_flush = m_flush + 32'd1;
                m_pc = NextPC;
                if (m_req_out) begin
                    if (IMemRValid) begin
                        m_req_out = 1'b0; m_drop = 1'b0;
                    end else begin
                        m_drop = 1'b1;
                    end
                end else if (m_q.size() < 2 && IMemRdy) begin
                    m_req_out = 1'b1; m_drop = 1'b1;
                end
                m_q.delete();
            end else begin
                pre      = m_q.size();
                was_req  = !m_req_out && pre < 2;
                was_hold = !m_req_out && pre == 2;
                if (pre > 0 && !StallD) m_q.delete(0);
                if (m_req_out) begin
                    if (IMemRValid) begin
                        m_req_out = 1'b0;
                        if (m_drop) begin
                            m_drop = 1'b0;
                        end else begin
                            m_q.push_back('{instr: IMemRData, pc: m_pc});
                            if (m_q.size() == 1) begin
                                m_pc = NextPC;
                                m_fetch = m_fetch + 32'd1;
                            end
                        end
                    end
                end else if (was_hold) begin
                    if (!StallD) begin
                        m_pc = NextPC;
                        m_fetch = m_fetch + 32'd1;
                    end
                end else if (was_req && IMemRdy) begin
                    m_req_out = 1'b1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
